// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, hazard/jump controls from decode,
// and the IF/ID register contents presented to decode.
interface fetch_unit_if #(
  parameter int PC_WIDTH = 16
);
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic                stall;
  logic [1:0]          JMPSel;
  logic                cond_fail;
  logic [PC_WIDTH-1:0] reg_target;
  logic [4:0]          OPcode;
  logic [2:0]          ALUop;
  logic [31:0]         id_instr;
  logic [PC_WIDTH-1:0] id_pc;
  logic                id_valid;
  logic                redirect;

  modport master (
    output imem_addr, OPcode, ALUop, id_instr, id_pc, id_valid, redirect,
    input  imem_rdata, stall, JMPSel, cond_fail, reg_target
  );

  modport slave (
    input  imem_addr, OPcode, ALUop, id_instr, id_pc, id_valid, redirect,
    output imem_rdata, stall, JMPSel, cond_fail, reg_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch and IF/ID stage: PC sequencing, synchronous-read imem,
// one-entry skid buffer for stalls, and redirect/squash on taken jumps.
module fetch_unit #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    JMP_SEQ     = 2'b00,
    JMP_REL     = 2'b01,
    JMP_REG     = 2'b10,
    JMP_SEQ_ALT = 2'b11
  } jmp_sel_e;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] fpc_q, fpc_d;
  logic                r_valid_q, r_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic [31:0]         skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic                id_valid_q, id_valid_d;
  logic [31:0]         id_instr_q, id_instr_d;
  logic [PC_WIDTH-1:0] id_pc_q, id_pc_d;

  jmp_sel_e            jmp_sel;
  logic                is_jump;
  logic                redirect;
  logic [PC_WIDTH-1:0] rel_offset;
  logic [PC_WIDTH-1:0] target;

  // Jump decode and target; an X on JMPSel is masked by id_valid_q=0.
  always_comb begin
    jmp_sel    = jmp_sel_e'(bus.JMPSel);
    is_jump    = (jmp_sel == JMP_REL) || (jmp_sel == JMP_REG);
    redirect   = id_valid_q & ~bus.stall & ~bus.cond_fail & is_jump;
    rel_offset = PC_WIDTH'($signed(id_instr_q[15:0]));
    target     = (jmp_sel == JMP_REG) ? bus.reg_target
                                      : id_pc_q + PC_WIDTH'(1) + rel_offset;
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the
    // branches below leaves a signal unassigned and infers a latch.
    pc_d         = pc_q;
    fpc_d        = pc_q;
    r_valid_d    = ~bus.stall & ~redirect;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;

    if (!bus.stall) begin
      pc_d = redirect ? target : pc_q + PC_WIDTH'(1);
    end

    // The skid catches the word that arrives in the first stall cycle,
    // because the PC is already past it and it would otherwise be lost.
    if (bus.stall) begin
      if (r_valid_q && !skid_valid_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = bus.imem_rdata;
        skid_pc_d    = fpc_q;
      end
    end else begin
      skid_valid_d = 1'b0;
    end

    if (!bus.stall) begin
      if (redirect) begin
        id_valid_d = 1'b0;
      end else if (skid_valid_q) begin
        id_valid_d = 1'b1;
        id_instr_d = skid_instr_q;
        id_pc_d    = skid_pc_q;
      end else begin
        id_valid_d = r_valid_q;
        id_instr_d = bus.imem_rdata;
        id_pc_d    = fpc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      fpc_q        <= RESET_PC;
      r_valid_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      fpc_q        <= fpc_d;
      r_valid_q    <= r_valid_d;
      skid_valid_q <= skid_valid_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
    end
  end

  // NOTE: skid payload is only read while skid_valid_q is set, so it is
  // left unreset like a memory and kept out of the reset block.
  always_ff @(posedge clk) begin
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
  end

  assign bus.imem_addr = pc_q;
  assign bus.OPcode    = id_instr_q[31:27];
  assign bus.ALUop     = id_instr_q[26:24];
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.redirect  = redirect;

endmodule
